// File: rtl/inst_fetch_req_if.sv
// Instruction SRAM request/response port and the IF-stage handoff of the pre-IF stage.
interface inst_fetch_req_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        fs_allow_in;
  logic        to_fs_valid;
  logic [31:0] to_fs_pc;
  logic [31:0] to_fs_inst;

  modport master (
    output inst_sram_req, inst_sram_addr, to_fs_valid, to_fs_pc, to_fs_inst,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, fs_allow_in
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr, to_fs_valid, to_fs_pc, to_fs_inst,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, fs_allow_in
  );
endinterface

// File: rtl/inst_fetch_req.sv
// Pre-IF stage: owns next_pc, keeps one instruction request in flight, hands
// returned words to IF and squashes wrong-path fetches after a redirect.
module inst_fetch_req #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  inst_fetch_req_if.master      bus
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]      state_q,    state_d;
  logic [XLEN-1:0] next_pc_q,  next_pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;
  logic            discard_q,  discard_d;

  logic            in_wait;
  logic            in_hold;
  logic            live_data;
  logic [XLEN-1:0] seq_pc;

  assign in_wait   = (state_q == ST_WAIT);
  assign in_hold   = (state_q == ST_HOLD);
  assign live_data = in_wait && bus.inst_sram_data_ok && !discard_q;
  assign seq_pc    = XLEN'(fetch_pc_q + XLEN'(4));

  assign bus.inst_sram_req  = (state_q == ST_REQ);
  assign bus.inst_sram_addr = next_pc_q;
  // A redirect squashes whatever is being presented in the same cycle.
  assign bus.to_fs_valid    = !br_taken && (live_data || in_hold);
  assign bus.to_fs_pc       = fetch_pc_q;
  assign bus.to_fs_inst     = in_hold   ? inst_buf_q :
                              live_data ? bus.inst_sram_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RST;
      next_pc_q  <= RESET_PC;
      fetch_pc_q <= '0;
      inst_buf_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      fetch_pc_q <= fetch_pc_d;
      inst_buf_q <= inst_buf_d;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    next_pc_d  = next_pc_q;
    fetch_pc_d = fetch_pc_q;
    inst_buf_d = inst_buf_q;
    discard_d  = discard_q;

    case (state_q)
      ST_RST: state_d = ST_REQ;
      ST_REQ: begin
        if (bus.inst_sram_addr_ok) begin
          fetch_pc_d = next_pc_q;
          state_d    = ST_WAIT;
          if (br_taken) discard_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.inst_sram_data_ok) begin
          if (br_taken || discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else if (bus.fs_allow_in) begin
            next_pc_d = seq_pc;
            state_d   = ST_REQ;
          end else begin
            inst_buf_d = bus.inst_sram_rdata;
            state_d    = ST_HOLD;
          end
        end else if (br_taken) begin
          discard_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          state_d = ST_REQ;
        end else if (bus.fs_allow_in) begin
          next_pc_d = seq_pc;
          state_d   = ST_REQ;
        end
      end
      default: state_d = ST_RST;
    endcase

    // Redirect target wins over the sequential PC; low bits are not part of a word address.
    if (br_taken) next_pc_d = br_target & ~XLEN'(3);
  end

endmodule

// File: tb/tb_inst_fetch_req.sv
// Directed + randomized bench for inst_fetch_req against a program-order model
// with a single-outstanding SRAM responder.
module tb_inst_fetch_req;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_taken;
  logic [31:0] br_target;

  inst_fetch_req_if bus();

  inst_fetch_req #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .br_taken  (br_taken),
    .br_target (br_target),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned consumed = 0;

  logic [31:0] want_pc;
  logic        outstanding;
  logic [31:0] out_addr;
  int unsigned cnt;
  int unsigned lat_lo, lat_hi;
  logic        stray, rel_rst;
  logic        d_br, d_allow, d_aok, real_ok;
  logic [31:0] d_tgt;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a3c3c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check at negedge+1, advance model at posedge.
  task automatic cyc(input logic br, input logic [31:0] tgt, input logic allow, input logic aok);
    @(negedge clk);
    if (rel_rst) begin
      reset   = 1'b1;
      rel_rst = 1'b0;
    end
    d_br = br; d_tgt = tgt; d_allow = allow; d_aok = aok;
    real_ok = outstanding && (cnt == 0);
    br_taken              = br;
    br_target             = tgt;
    bus.fs_allow_in       = allow;
    bus.inst_sram_addr_ok = aok;
    bus.inst_sram_data_ok = real_ok || stray;
    bus.inst_sram_rdata   = real_ok ? mem(out_addr) : $urandom;
    #1;
    s_req = bus.inst_sram_req; s_addr = bus.inst_sram_addr;
    s_valid = bus.to_fs_valid; s_pc = bus.to_fs_pc; s_inst = bus.to_fs_inst;
    chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
    if (s_req) begin
      chk("req_addr", s_addr, want_pc);
      chk("one_outstanding", {31'd0, outstanding}, 32'd0);
    end
    if (s_valid) begin
      chk("valid_under_br", {31'd0, d_br}, 32'd0);
      chk("fs_pc", s_pc, want_pc);
      chk("fs_inst", s_inst, mem(want_pc));
    end
    @(posedge clk);
    if (real_ok) outstanding = 1'b0;
    else if (outstanding) cnt--;
    if (s_req && d_aok) begin
      outstanding = 1'b1;
      out_addr    = s_addr;
      cnt         = $urandom_range(lat_hi, lat_lo);
    end
    if (s_valid && d_allow) begin
      want_pc = want_pc + 32'd4;
      consumed++;
    end
    if (d_br) want_pc = d_tgt & ~32'd3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, bus.inst_sram_req}, 32'd0);
    chk({tag, "_addr"},  bus.inst_sram_addr, RESET_PC);
    chk({tag, "_valid"}, {31'd0, bus.to_fs_valid}, 32'd0);
    chk({tag, "_pc"},    bus.to_fs_pc, 32'd0);
    chk({tag, "_inst"},  bus.to_fs_inst, 32'd0);
  endtask

  initial begin
    reset = 1'b0; br_taken = 1'b0; br_target = '0;
    bus.fs_allow_in = 1'b1; bus.inst_sram_addr_ok = 1'b1;
    bus.inst_sram_data_ok = 1'b1; bus.inst_sram_rdata = 32'hdeadbeef;
    want_pc = RESET_PC; outstanding = 1'b0; out_addr = '0; cnt = 0;
    lat_lo = 0; lat_hi = 0; stray = 1'b0; rel_rst = 1'b0;
    #12;
    chk_reset_outputs("reset");

    // Back-to-back fetch with an ideal SRAM.
    rel_rst = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("first_cycle_noreq", {31'd0, s_req}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("seq_req", {31'd0, s_req}, 32'(k % 2));
      if (k % 2 == 1) chk("seq_addr", s_addr, RESET_PC + 32'(4 * (k / 2)));
      if (k == 2) begin
        chk("seq_valid", {31'd0, s_valid}, 32'd1);
        chk("seq_pc", s_pc, RESET_PC);
      end
    end

    // IF stalls for 3 cycles when 0x1c000004 returns.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("hold_valid", {31'd0, s_valid}, 32'd1);
      chk("hold_pc", s_pc, 32'h1c000004);
      chk("hold_inst", s_inst, mem(32'h1c000004));
      chk("hold_noreq", {31'd0, s_req}, 32'd0);
    end
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("hold_release", {31'd0, s_valid}, 32'd1);
    lat_lo = 1; lat_hi = 1;
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("after_hold_req", {31'd0, s_req}, 32'd1);
    chk("after_hold_addr", s_addr, 32'h1c000008);

    // Redirect while waiting: late data must be dropped.
    lat_lo = 0; lat_hi = 0;
    cyc(1'b1, 32'h1c000100, 1'b1, 1'b1);
    chk("br_wait_valid", {31'd0, s_valid}, 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("dropped_valid", {31'd0, s_valid}, 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("redir_addr", s_addr, 32'h1c000100);

    // Redirect coinciding with data_ok; misaligned target.
    cyc(1'b1, 32'h1c000202, 1'b1, 1'b1);
    chk("br_data_valid", {31'd0, s_valid}, 32'd0);

    // Redirect in REQ with addr_ok held low.
    cyc(1'b1, 32'h1c000300, 1'b1, 1'b0);
    chk("req_br_old_addr", s_addr, 32'h1c000200);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("req_br_new_addr", s_addr, 32'h1c000300);
    lat_lo = 2; lat_hi = 2;
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("req_br_accept", {31'd0, s_req}, 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b1);

    // Reset while in WAIT, then a stray data_ok after release.
    @(negedge clk);
    reset = 1'b0;
    bus.inst_sram_data_ok = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    want_pc = RESET_PC; outstanding = 1'b0;
    @(posedge clk);
    lat_lo = 0; lat_hi = 0; stray = 1'b1; rel_rst = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stray_rst_valid", {31'd0, s_valid}, 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("stray_req_valid", {31'd0, s_valid}, 32'd0);
    chk("post_reset_addr", s_addr, RESET_PC);
    stray = 1'b0;

    // Randomized traffic, including redirects near the top of the address space.
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(3, 0) == 0) ? (32'hfffffff0 | 32'($urandom_range(15, 0))) : $urandom;
      cyc(($urandom_range(9, 0) == 0), t, ($urandom_range(3, 0) != 0), 1'($urandom));
    end
    chk("liveness", {31'd0, consumed > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_req.md
# inst_fetch_req

Pre-IF stage of the LA32R five-stage pipeline: owns the next-fetch PC, issues instruction requests on the SRAM-like instruction port, and presents each returned instruction with its PC to the IF stage through the valid/allow-in handshake. It handles branch redirects from downstream while a request is in flight. Any instruction fetched from the wrong path is discarded and never reaches IF. At most one request is outstanding at any time.

## Interface

Parameters
- RESET_PC, 32'h1c000000, address of the first fetch after reset.

Ports
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- br_taken  in  1  redirect request; valid for one cycle per redirect.
- br_target  in  32  redirect address; sampled when br_taken=1.
- fs_allow_in  in  1  IF stage accepts the presented instruction this cycle.
- inst_sram_req  out  1  instruction request valid.
- inst_sram_addr  out  32  request address; word-aligned.
- inst_sram_addr_ok  in  1  request accepted this cycle; meaningful only when inst_sram_req=1.
- inst_sram_data_ok  in  1  read data returned this cycle.
- inst_sram_rdata  in  32  returned instruction word.
- to_fs_valid  out  1  an instruction is presented to IF.
- to_fs_pc  out  32  PC of the presented instruction.
- to_fs_inst  out  32  presented instruction word.

## Operation

- Registers:
  - next_pc (32)
  - fetch_pc (32), the PC of the outstanding or held instruction
  - inst_buf (32)
  - discard (1)
  - state (2)
- State machine:
  - RST: entered on reset. Moves to REQ on the first clock edge after reset deasserts.
  - REQ: inst_sram_req=1 and inst_sram_addr=next_pc.
    - On addr_ok=1: fetch_pc <= next_pc, state <= WAIT.
  - WAIT: inst_sram_req=0; waiting for data_ok.
    - data_ok=1 with discard=1: drop the data, clear discard, state <= REQ.
    - data_ok=1 with discard=0 and fs_allow_in=1: present rdata directly (to_fs_valid=1, to_fs_inst=rdata, to_fs_pc=fetch_pc). next_pc <= fetch_pc+4, state <= REQ.
    - data_ok=1 with discard=0 and fs_allow_in=0: inst_buf <= rdata, state <= HOLD.
  - HOLD: to_fs_valid=1, to_fs_inst=inst_buf, to_fs_pc=fetch_pc.
    - On fs_allow_in=1: next_pc <= fetch_pc+4, state <= REQ.
- Redirect (br_taken=1) overrides every other action in the same cycle. It forces to_fs_valid=0 in that cycle, and next_pc <= br_target. Then, by state:
  - REQ, addr_ok=0: state stays REQ. The target address is driven from the next cycle.
  - REQ, addr_ok=1: the old address is accepted. discard <= 1, state <= WAIT.
  - WAIT, data_ok=0: discard <= 1.
  - WAIT, data_ok=1: the data is dropped, state <= REQ.
  - HOLD: the buffer is dropped, state <= REQ.
- Arithmetic: PC increment is modulo 2^32 (32'hfffffffc + 4 = 32'h0). br_target[1:0] is ignored and forced to 0 in next_pc.
- inst_sram_addr is held stable while inst_sram_req=1. It changes only in a cycle following a redirect that was not accepted.
- to_fs_valid is never asserted in RST or REQ.

## Timing

- Reset values, while reset=0:
  - state=RST, next_pc=RESET_PC, fetch_pc=0, inst_buf=0, discard=0
  - inst_sram_req=0, inst_sram_addr=RESET_PC
  - to_fs_valid=0, to_fs_pc=0, to_fs_inst=0
- Reset asserted mid-transaction: all state is cleared immediately. A data_ok arriving after reset deasserts is ignored, because the state is RST or REQ.
- Best-case latency:
  - cycle N: req accepted (addr_ok=1)
  - cycle N+1: data_ok=1 and to_fs_valid=1
  - cycle N+2: next req
  - Peak throughput is one instruction per 2 cycles.
- to_fs_valid and to_fs_inst are combinational from inst_sram_data_ok and inst_sram_rdata in WAIT, and registered in HOLD.
- An instruction is consumed in the cycle where to_fs_valid=1 and fs_allow_in=1.
- inst_sram_data_ok outside WAIT is a protocol error and is ignored.

## Test plan

- Reset then an SRAM with addr_ok=1 and data_ok one cycle later, fs_allow_in=1:
  - requests go to 0x1c000000, 0x1c000004, 0x1c000008 in cycles 1, 3, 5 after reset release.
  - to_fs_valid pulses with the matching PCs.
- fs_allow_in=0 for 3 cycles when data for 0x1c000004 returns:
  - HOLD presents the buffered instruction with a stable PC and inst for all 3 cycles.
  - No new req is issued.
  - After release, the next req is 0x1c000008.
- br_taken=1 with target 0x1c000100 while in WAIT for 0x1c000008:
  - the later data_ok is dropped and to_fs_valid stays 0.
  - The next request address is 0x1c000100.
- br_taken in the same cycle as data_ok in WAIT:
  - to_fs_valid=0 in that cycle.
  - The next req address is the target.
- br_taken in REQ with addr_ok held 0 for 2 cycles:
  - the address switches to the target one cycle after br_taken.
  - The old address is never fetched.
- reset asserted while in WAIT:
  - outputs return to reset values immediately.
  - A stray data_ok after release produces no to_fs_valid.
  - The first req is RESET_PC.
